// File: rtl/psrm0_pkg.sv
// Shared psrm0 neuron types and default constants.
// Used by the membrane/fire stage and the summation stage bench.
package psrm0_pkg;

    localparam int V_WIDTH = 14;

    typedef logic [V_WIDTH-1:0] voltage_t;

    typedef enum logic [1:0] {
        INTEGRATE,
        FIRE,
        REFRACT
    } fire_state_t;

    localparam voltage_t    DEF_THRESHOLD    = voltage_t'(1000);
    localparam voltage_t    DEF_V_RESET      = '0;
    localparam int          DEF_DECAY_SHIFT  = 3;
    localparam int unsigned DEF_REFRAC_TICKS = 4;

    // Cannot underflow: v >> shift never exceeds v.
    function automatic voltage_t cond_decay(voltage_t v, int shift);
        return v - (v >> shift);
    endfunction

endpackage

// File: rtl/membrane_fire_if.sv
// Tick/voltage/clear inputs and membrane/spike outputs of membrane_fire.
// o_spike_count and CNT_WIDTH exist only when SPIKE_COUNT_EN is defined.
interface membrane_fire_if
`ifdef SPIKE_COUNT_EN
    #(parameter int CNT_WIDTH = 16)
`endif
    ;
    import psrm0_pkg::*;

    logic     i_tick;
    voltage_t i_sum_voltage;
    logic     i_clear;
    voltage_t o_membrane;
    voltage_t o_cond_decay;
    logic     o_spike;
    logic     o_refractory;
`ifdef SPIKE_COUNT_EN
    logic [CNT_WIDTH-1:0] o_spike_count;
`endif

    modport master (
        output i_tick, i_sum_voltage, i_clear,
`ifdef SPIKE_COUNT_EN
        input  o_spike_count,
`endif
        input  o_membrane, o_cond_decay, o_spike, o_refractory
    );

    modport slave (
        input  i_tick, i_sum_voltage, i_clear,
`ifdef SPIKE_COUNT_EN
        output o_spike_count,
`endif
        output o_membrane, o_cond_decay, o_spike, o_refractory
    );

endinterface

// File: rtl/membrane_fire_refractory_timer.sv
// Refractory down-counter: load wins over tick; done flags the tick that reaches zero.
module refractory_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic          done,
    output logic          busy
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && busy) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    assign done = tick && (cnt == CW'(1));

endmodule

// File: rtl/membrane_fire.sv
// psrm0 membrane register, threshold/fire FSM and conductance-decay feedback.
// SPIKE_COUNT_EN adds a saturating spike counter on o_spike_count.
//
// state     | meaning
// INTEGRATE | ticks load the membrane; at/above threshold fires
// FIRE      | one-clock spike; ticks discarded
// REFRACT   | membrane held at V_RESET; ticks count down the timer
module membrane_fire
    import psrm0_pkg::*;
#(
    parameter voltage_t    THRESHOLD    = DEF_THRESHOLD,
    parameter voltage_t    V_RESET      = DEF_V_RESET,
    parameter int          DECAY_SHIFT  = DEF_DECAY_SHIFT,
    parameter int unsigned REFRAC_TICKS = DEF_REFRAC_TICKS
) (
    input  logic           clk,
    input  logic           reset,
    membrane_fire_if.slave bus
);

    localparam int RT_W = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;

    fire_state_t     state;
    logic            fire_evt;
    logic            tmr_load;
    logic [RT_W-1:0] tmr_load_val;
    logic            tmr_tick;
    logic            tmr_done;
    logic            tmr_busy;

    assign fire_evt = (state == INTEGRATE) && bus.i_tick && !bus.i_clear
                      && (bus.i_sum_voltage >= THRESHOLD);

    // Clearing reloads the timer with zero instead of needing a separate port.
    assign tmr_load     = fire_evt || bus.i_clear;
    assign tmr_load_val = bus.i_clear ? '0 : RT_W'(REFRAC_TICKS);
    assign tmr_tick     = (state == REFRACT) && bus.i_tick;

    refractory_timer #(.CW(RT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tick     (tmr_tick),
        .done     (tmr_done),
        .busy     (tmr_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= INTEGRATE;
            bus.o_membrane   <= V_RESET;
            bus.o_spike      <= 1'b0;
            bus.o_refractory <= 1'b0;
        end else if (bus.i_clear) begin
            state            <= INTEGRATE;
            bus.o_membrane   <= V_RESET;
            bus.o_spike      <= 1'b0;
            bus.o_refractory <= 1'b0;
        end else begin
            case (state)
                INTEGRATE: begin
                    if (fire_evt) begin
                        state            <= FIRE;
                        bus.o_membrane   <= V_RESET;
                        bus.o_spike      <= 1'b1;
                        bus.o_refractory <= 1'b1;
                    end else if (bus.i_tick) begin
                        bus.o_membrane <= bus.i_sum_voltage;
                    end
                end
                FIRE: begin
                    // Timer is busy here exactly when a refractory period was loaded.
                    bus.o_spike <= 1'b0;
                    if (tmr_busy) begin
                        state <= REFRACT;
                    end else begin
                        state            <= INTEGRATE;
                        bus.o_refractory <= 1'b0;
                    end
                end
                REFRACT: begin
                    if (tmr_done) begin
                        state            <= INTEGRATE;
                        bus.o_refractory <= 1'b0;
                    end
                end
                default: begin
                    state            <= INTEGRATE;
                    bus.o_membrane   <= V_RESET;
                    bus.o_spike      <= 1'b0;
                    bus.o_refractory <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_cond_decay = cond_decay(bus.o_membrane, DECAY_SHIFT);

`ifdef SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.o_spike_count <= '0;
        end else if (fire_evt && !(&bus.o_spike_count)) begin
            bus.o_spike_count <= bus.o_spike_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_membrane_fire.sv
// Bench for membrane_fire: two instances (4 and 0 refractory ticks) against a behavioural model.
module tb_membrane_fire;
    import psrm0_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    membrane_fire_if bus0 ();
`ifdef SPIKE_COUNT_EN
    membrane_fire_if #(.CNT_WIDTH(2)) bus1 ();
`else
    membrane_fire_if bus1 ();
`endif

    membrane_fire #(.REFRAC_TICKS(4)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0.slave));
    membrane_fire #(.REFRAC_TICKS(0)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: refractory length and counter ceiling per instance.
    int m_mem   [2];
    int m_spike [2];
    int m_fire  [2];
    int m_left  [2];
    int m_cnt   [2];
    int refr    [2] = '{4, 0};
    int cmax    [2] = '{65535, 3};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mem[d] = 0; m_spike[d] = 0; m_fire[d] = 0; m_left[d] = 0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_clock(input int d, input bit t, input int s, input bit c);
        if (c) begin
            m_mem[d] = 0; m_spike[d] = 0; m_fire[d] = 0; m_left[d] = 0;
        end else if (m_fire[d] != 0) begin
            m_fire[d] = 0; m_spike[d] = 0;
        end else if (m_left[d] > 0) begin
            if (t) m_left[d]--;
        end else if (t) begin
            if (s >= 1000) begin
                m_mem[d] = 0; m_spike[d] = 1; m_fire[d] = 1; m_left[d] = refr[d];
                if (m_cnt[d] < cmax[d]) m_cnt[d]++;
            end else begin
                m_mem[d] = s;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("d0 membrane",   32'(bus0.o_membrane),   32'(m_mem[0]));
        check("d0 cond_decay", 32'(bus0.o_cond_decay), 32'(m_mem[0] - m_mem[0] / 8));
        check("d0 spike",      32'(bus0.o_spike),      32'(m_spike[0]));
        check("d0 refractory", 32'(bus0.o_refractory), 32'((m_fire[0] != 0) || (m_left[0] > 0)));
        check("d1 membrane",   32'(bus1.o_membrane),   32'(m_mem[1]));
        check("d1 cond_decay", 32'(bus1.o_cond_decay), 32'(m_mem[1] - m_mem[1] / 8));
        check("d1 spike",      32'(bus1.o_spike),      32'(m_spike[1]));
        check("d1 refractory", 32'(bus1.o_refractory), 32'((m_fire[1] != 0) || (m_left[1] > 0)));
`ifdef SPIKE_COUNT_EN
        check("d0 spike_count", 32'(bus0.o_spike_count), 32'(m_cnt[0]));
        check("d1 spike_count", 32'(bus1.o_spike_count), 32'(m_cnt[1]));
`endif
    endtask

    task automatic cycle(input bit t, input int s, input bit c);
        bus0.i_tick = t; bus0.i_sum_voltage = voltage_t'(s); bus0.i_clear = c;
        bus1.i_tick = t; bus1.i_sum_voltage = voltage_t'(s); bus1.i_clear = c;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_clock(0, t, s, c);
            model_clock(1, t, s, c);
        end
        #1;
        check_all();
    endtask

    initial begin
        int t;
        int s;
        int c;

        // Reset held with an active above-threshold tick.
        rst_n = 1'b0;
        model_reset();
        repeat (3) cycle(1, 2000, 0);
        rst_n = 1'b1;
        cycle(0, 0, 0);

        // Sub-threshold integration.
        cycle(1, 800, 0);
        cycle(0, 0, 0);
        cycle(1, 999, 0);
        cycle(0, 0, 0);

        // Fire exactly at threshold, then four refractory ticks, then fire again.
        cycle(1, 1000, 0);
        cycle(0, 0, 0);
        repeat (4) begin
            cycle(1, 1500, 0);
            cycle(0, 0, 0);
        end
        cycle(1, 1500, 0);
        cycle(0, 0, 0);
        repeat (4) cycle(1, 1500, 0);
        cycle(0, 0, 0);

        // Full-scale input; tick in the FIRE clock is discarded.
        cycle(1, 16383, 0);
        cycle(1, 1500, 0);
        repeat (4) cycle(1, 1500, 0);
        cycle(1, 1500, 0);
        repeat (6) cycle(1, 1500, 0);

        // Clear mid-refractory, integrate, then clear beats a firing tick.
        cycle(0, 0, 1);
        cycle(1, 1200, 0);
        cycle(0, 0, 0);
        cycle(1, 1500, 0);
        cycle(1, 1500, 0);
        cycle(0, 0, 1);
        cycle(1, 500, 0);
        cycle(1, 2000, 1);
        cycle(0, 0, 0);

        // Asynchronous reset between edges while refractory.
        cycle(1, 1200, 0);
        cycle(0, 0, 0);
        cycle(1, 100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) cycle(0, 0, 0);
        rst_n = 1'b1;
        repeat (10) cycle(1, 1500, 0);

        // Randomized traffic around the threshold.
        for (int i = 0; i < 400; i++) begin
            t = int'($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       s = 999;
                1:       s = 1000;
                2:       s = int'($urandom_range(0, 16383));
                default: s = int'($urandom_range(0, 1999));
            endcase
            c = int'($urandom_range(0, 31) == 0);
            cycle(t[0], s, c[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
